// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - key event handshake between keypad scanner and request logic
interface keypad_scan_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad column scanner with held-key suppression and key FIFO
module keypad_scan #(
  parameter int SCAN_DIV   = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        button_mux,
  output logic [3:0]        columns,
  output logic              en,
  output logic              overflow,
  keypad_scan_if.master     key
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_SETTLE = 2'd0,
    S_DWELL  = 2'd1,
    S_COMMIT = 2'd2,
    S_PUSH   = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [1:0]      col;
  logic [CW-1:0]   cnt;
  logic [3:0]      capture;
  logic [3:0]      pend;
  logic [3:0]      new_mask;
  logic [3:0][3:0] held;
  logic [3:0]      low_onehot;
  logic [1:0]      low_row;
  logic            push;
  logic            push_ok;
  logic            pop;
  logic            advance;
  logic            full;
  logic            empty;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [3:0]      mem [FIFO_DEPTH];

  // Rows pressed this visit that were not already held from the previous visit
  assign new_mask = capture & ~held[col];
  assign columns  = 4'b0001 << col;

  // Lowest pending row is pushed first so a multi-key column drains in ascending row order
  always_comb begin
    low_row    = 2'd0;
    low_onehot = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) begin
        low_row       = 2'(i);
        low_onehot    = 4'b0000;
        low_onehot[i] = 1'b1;
      end
    end
  end

  // Scan state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_SETTLE;
    else     state <= next_state;
  end

  // Next-state and per-state strobes; debouncer only enabled while dwelling
  always_comb begin
    next_state = state;
    en         = 1'b0;
    push       = 1'b0;
    advance    = 1'b0;
    case (state)
      S_SETTLE: next_state = S_DWELL;
      S_DWELL: begin
        en = 1'b1;
        if (cnt == CW'(SCAN_DIV - 1)) next_state = S_COMMIT;
      end
      S_COMMIT: begin
        if (new_mask == 4'b0000) begin
          advance    = 1'b1;
          next_state = S_SETTLE;
        end else begin
          next_state = S_PUSH;
        end
      end
      S_PUSH: begin
        push = 1'b1;
        if ((pend & ~low_onehot) == 4'b0000) begin
          advance    = 1'b1;
          next_state = S_SETTLE;
        end
      end
      default: next_state = S_SETTLE;
    endcase
  end

  // Column pointer, dwell counter, press capture and held-key memory
  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= 2'd0;
      cnt     <= '0;
      capture <= 4'b0000;
      pend    <= 4'b0000;
      held    <= '0;
    end else begin
      case (state)
        S_SETTLE: begin
          capture <= 4'b0000;
          cnt     <= '0;
        end
        S_DWELL: begin
          capture <= capture | button_mux;
          cnt     <= cnt + CW'(1);
        end
        S_COMMIT: begin
          held[col] <= capture;
          pend      <= new_mask;
        end
        S_PUSH: pend <= pend & ~low_onehot;
        default: ;
      endcase
      if (advance) col <= col + 2'd1;
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign key.key_valid = ~empty;
  assign key.key_code  = empty ? 4'h0 : mem[rd_ptr[AW-1:0]];
  assign pop           = key.key_valid & key.key_ready;
  assign push_ok       = push & (~full | pop);

  // FIFO pointers and sticky drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {low_row, col};
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan
module tb_keypad_scan;

  localparam int SD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] button_mux;
  logic [3:0] columns;
  logic       en;
  logic       overflow;

  keypad_scan_if kif ();

  keypad_scan #(.SCAN_DIV(SD), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .button_mux (button_mux),
    .columns    (columns),
    .en         (en),
    .overflow   (overflow),
    .key        (kif)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  int         cyc;
  int         visits;
  int         dwell_idx;
  int         since_fall;
  int         ready_mode;
  bit         junk;
  bit         prev_en;
  logic [3:0] cur_mask;
  int         offs [4];
  logic [3:0] plan [$];
  logic [3:0] got [$];
  logic [3:0] seen_cols [$];
  int         starts [$];

  task automatic do_reset();
    rst = 1'b1;
    button_mux = 4'b0000;
    kif.key_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0; visits = 0; dwell_idx = 0; since_fall = 100; prev_en = 1'b0; cur_mask = 4'b0000;
    got.delete(); seen_cols.delete(); starts.delete(); plan.delete();
  endtask

  // One clock: advance, then drive this cycle's row pulses and ready, and log pops
  task automatic step();
    logic [3:0] bm;
    logic       kr;
    @(posedge clk);
    #1;
    cyc++;
    if (en && !prev_en) begin
      visits++;
      starts.push_back(cyc);
      seen_cols.push_back(columns);
      cur_mask = (plan.size() > 0) ? plan.pop_front() : 4'b0000;
      for (int r = 0; r < 4; r++) offs[r] = $urandom_range(0, SD - 1);
      dwell_idx = 0;
    end
    if (!en && prev_en) since_fall = 0;
    else if (!en)       since_fall++;
    prev_en = en;
    if (en) begin
      bm = 4'b0000;
      for (int r = 0; r < 4; r++) if (cur_mask[r] && offs[r] == dwell_idx) bm[r] = 1'b1;
      button_mux = bm;
      dwell_idx++;
    end else begin
      button_mux = junk ? 4'($urandom_range(0, 15)) : 4'b0000;
    end
    case (ready_mode)
      0:       kr = 1'b1;
      1:       kr = en ? 1'b1 : 1'($urandom_range(0, 1));
      2:       kr = 1'b0;
      default: kr = (visits == 2) && !en && (since_fall == 1);
    endcase
    kif.key_ready = kr;
    if (kif.key_valid && kif.key_ready) got.push_back(kif.key_code);
  endtask

  task automatic run_visits(input int n);
    int b = 0;
    while (visits < n && b < 3000) begin
      step();
      b++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; button_mux = 4'b0000; kif.key_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (columns !== 4'b0001) begin miscompares++; $display("FAIL reset_columns got=%b exp=0001", columns); end
    vectors++; if (en !== 1'b0) begin miscompares++; $display("FAIL reset_en got=%b exp=0", en); end
    vectors++; if (kif.key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_key_valid got=%b exp=0", kif.key_valid); end
    vectors++; if (kif.key_code !== 4'h0) begin miscompares++; $display("FAIL reset_key_code got=%h exp=0", kif.key_code); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      vectors++;
      if (en !== ((c >= 1 && c <= SD) ? 1'b1 : 1'b0)) begin
        miscompares++; $display("FAIL reset_en_cycle c=%0d got=%b", c, en);
      end
      vectors++;
      if (columns !== ((c <= SD + 1) ? 4'b0001 : 4'b0010)) begin
        miscompares++; $display("FAIL reset_col_cycle c=%0d got=%b", c, columns);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_single_press();
    do_reset();
    kif.key_ready = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      vectors++;
      if (kif.key_valid !== ((c == 21) ? 1'b1 : 1'b0)) begin
        miscompares++; $display("FAIL single_valid c=%0d got=%b", c, kif.key_valid);
      end
      if (c == 20) begin
        vectors++; if (columns !== 4'b0010 || en !== 1'b0) begin miscompares++; $display("FAIL single_push_cycle got cols=%b en=%b exp cols=0010 en=0", columns, en); end
      end
      if (c == 21) begin
        vectors++; if (kif.key_code !== 4'h9) begin miscompares++; $display("FAIL single_code got=%h exp=9", kif.key_code); end
        vectors++; if (columns !== 4'b0100) begin miscompares++; $display("FAIL single_next_col got=%b exp=0100", columns); end
      end
      button_mux = (c == 13) ? 4'b0100 : 4'b0000;
      @(posedge clk);
      #1;
    end
    button_mux = 4'b0000;
  endtask

  task automatic test_held_key();
    do_reset();
    ready_mode = 0; junk = 1'b0;
    for (int v = 0; v < 20; v++) plan.push_back((v == 1 || v == 5 || v == 9 || v == 17) ? 4'b0100 : 4'b0000);
    run_visits(21);
    repeat (10) step();
    vectors++; if (visits < 21) begin miscompares++; $display("FAIL held_progress got=%0d visits exp>=21", visits); end
    vectors++; if (got.size() !== 2) begin miscompares++; $display("FAIL held_count got=%0d exp=2", got.size()); end
    for (int i = 0; i < got.size() && i < 2; i++) begin
      vectors++; if (got[i] !== 4'h9) begin miscompares++; $display("FAIL held_code i=%0d got=%h exp=9", i, got[i]); end
    end
  endtask

  task automatic test_two_keys();
    do_reset();
    ready_mode = 0; junk = 1'b0;
    plan.push_back(4'b0000); plan.push_back(4'b0000); plan.push_back(4'b1001);
    run_visits(4);
    repeat (10) step();
    vectors++; if (starts.size() < 4) begin miscompares++; $display("FAIL two_progress got=%0d exp>=4", starts.size()); end
    else begin
      vectors++; if (starts[2] - starts[1] !== SD + 2) begin miscompares++; $display("FAIL two_idle_period got=%0d exp=%0d", starts[2] - starts[1], SD + 2); end
      vectors++; if (starts[3] - starts[2] !== SD + 4) begin miscompares++; $display("FAIL two_period got=%0d exp=%0d", starts[3] - starts[2], SD + 4); end
    end
    vectors++; if (got.size() !== 2) begin miscompares++; $display("FAIL two_count got=%0d exp=2", got.size()); end
    else begin
      vectors++; if (got[0] !== 4'h2 || got[1] !== 4'hE) begin miscompares++; $display("FAIL two_order got=%h,%h exp=2,e", got[0], got[1]); end
    end
  endtask

  task automatic test_full_pop();
    logic [3:0] exp [5];
    exp = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h1};
    do_reset();
    ready_mode = 3; junk = 1'b0;
    plan.push_back(4'b1111); plan.push_back(4'b0001);
    run_visits(3);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fullpop_overflow got=%b exp=0", overflow); end
    ready_mode = 0;
    repeat (8) step();
    vectors++; if (got.size() !== 5) begin miscompares++; $display("FAIL fullpop_count got=%0d exp=5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL fullpop_code i=%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [3:0] exp [4];
    exp = '{4'h4, 4'h1, 4'hE, 4'hB};
    do_reset();
    ready_mode = 2; junk = 1'b0;
    plan.push_back(4'b0010); plan.push_back(4'b0001); plan.push_back(4'b1000);
    plan.push_back(4'b0100); plan.push_back(4'b0100);
    run_visits(5);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_before got=%b exp=0", overflow); end
    vectors++; if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h4) begin miscompares++; $display("FAIL ovf_head got v=%b c=%h exp v=1 c=4", kif.key_valid, kif.key_code); end
    run_visits(6);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_after got=%b exp=1", overflow); end
    vectors++; if (kif.key_code !== 4'h4) begin miscompares++; $display("FAIL ovf_head_hold got=%h exp=4", kif.key_code); end
    ready_mode = 0;
    repeat (6) step();
    vectors++; if (got.size() !== 4) begin miscompares++; $display("FAIL ovf_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL ovf_code i=%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    vectors++; if (kif.key_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_drained got=%b exp=0", kif.key_valid); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_reset_mid();
    int target;
    ready_mode = 2; junk = 1'b0;
    plan.push_back(4'b1111); plan.push_back(4'b1111);
    target = visits + 3;
    run_visits(target);
    step();
    vectors++; if (kif.key_valid !== 1'b1 || en !== 1'b1) begin miscompares++; $display("FAIL mid_precond got v=%b en=%b exp 1,1", kif.key_valid, en); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (columns !== 4'b0001) begin miscompares++; $display("FAIL mid_columns got=%b exp=0001", columns); end
    vectors++; if (en !== 1'b0) begin miscompares++; $display("FAIL mid_en got=%b exp=0", en); end
    vectors++; if (kif.key_valid !== 1'b0 || kif.key_code !== 4'h0) begin miscompares++; $display("FAIL mid_fifo got v=%b c=%h exp 0,0", kif.key_valid, kif.key_code); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL mid_overflow got=%b exp=0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] hm [4];
    logic [3:0] exp [$];
    logic [3:0] m;
    int         c;
    do_reset();
    ready_mode = 1; junk = 1'b1;
    for (int k = 0; k < 4; k++) hm[k] = 4'b0000;
    for (int v = 0; v < 48; v++) begin
      c = v % 4;
      m = ($urandom_range(0, 1) == 1) ? hm[c] : 4'($urandom_range(0, 15));
      for (int r = 0; r < 4; r++) if (m[r] && !hm[c][r]) exp.push_back({2'(r), 2'(c)});
      hm[c] = m;
      plan.push_back(m);
    end
    run_visits(49);
    ready_mode = 0; junk = 1'b0;
    repeat (40) step();
    vectors++; if (got.size() !== exp.size()) begin miscompares++; $display("FAIL rand_count got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL rand_code i=%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    for (int k = 0; k < seen_cols.size(); k++) begin
      vectors++; if (seen_cols[k] !== (4'b0001 << (k % 4))) begin miscompares++; $display("FAIL rand_column k=%0d got=%b", k, seen_cols[k]); end
    end
    vectors++; if (overflow !== 1'b0 || kif.key_valid !== 1'b0) begin miscompares++; $display("FAIL rand_end got ovf=%b v=%b exp 0,0", overflow, kif.key_valid); end
  endtask

  initial begin
    rst = 1'b1; button_mux = 4'b0000; kif.key_ready = 1'b0;
    ready_mode = 0; junk = 1'b0;
    test_reset();
    test_single_press();
    test_held_key();
    test_two_keys();
    test_full_pop();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
